// File: rtl/multicycle_alu.sv
// Signed add/sub/logic/mul ALU with saturate-or-wrap overflow; 1-cycle latency, mul WIDTH+1 cycles.
// Single operation in flight: in_ready only while idle, result held in DONE until out_ready.
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic             overflow,
    output logic             err,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic signed [PW-1:0] MAX_V = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              sticky_q, sticky_d;

    logic [WIDTH-1:0]  mag_a, mag_b, bit_r;
    logic [WIDTH:0]    sum;
    logic [PW-1:0]     prod_next;
    logic signed [PW-1:0] full;
    logic              load, sat_use, err_new, ovf_new;

    // Magnitude of the most negative value still fits when read as unsigned.
    assign mag_a     = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign mag_b     = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        sat_d    = sat_q;
        q_d      = q_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        sum      = '0;
        bit_r    = '0;
        full     = '0;
        load     = 1'b0;
        sat_use  = sat_q;
        err_new  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (sel == 3'b100) begin
                        state_d  = MUL;
                        mcand_d  = {{WIDTH{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        prod_d   = '0;
                        cnt_d    = '0;
                        neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
                        sat_d    = sat;
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                        sat_use = sat;
                        case (sel)
                            3'b000:  sum   = {A[WIDTH-1], A} + {B[WIDTH-1], B};
                            3'b001:  sum   = {A[WIDTH-1], A} - {B[WIDTH-1], B};
                            3'b010:  bit_r = A | B;
                            3'b011:  bit_r = A & B;
                            3'b101:  bit_r = A ^ B;
                            default: err_new = 1'b1;
                        endcase
                        if (sel[2:1] == 2'b00)
                            full = {{(WIDTH-1){sum[WIDTH]}}, sum};
                        else
                            full = {{WIDTH{bit_r[WIDTH-1]}}, bit_r};
                    end
                end
            end
            MUL: begin
                prod_d   = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    load    = 1'b1;
                    full    = neg_q ? (~prod_next + 1'b1) : prod_next;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ovf_new = load && ((full > MAX_V) || (full < MIN_V));
        if (load) begin
            q_d = full[WIDTH-1:0];
            if (ovf_new && sat_use)
                q_d = full[PW-1] ? MIN_V[WIDTH-1:0] : MAX_V[WIDTH-1:0];
            ovf_d = ovf_new;
            err_d = err_new;
        end
        // A new overflow beats a coincident clear.
        sticky_d = ovf_new | (sticky_q & ~clr_sticky);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            sat_q    <= 1'b0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            sat_q    <= sat_d;
            q_q      <= q_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign Q          = q_q;
    assign overflow   = ovf_q;
    assign err        = err_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized and directed bench for multicycle_alu (WIDTH=8) against an integer reference model.
module tb_multicycle_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   sel = '0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Q;
    logic         overflow;
    logic         err;
    logic         ovf_sticky;
    logic         clr_sticky = 1'b0;

    int checks = 0;
    int failures = 0;
    bit st_m = 1'b0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .sel        (sel),
        .sat        (sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Q          (Q),
        .overflow   (overflow),
        .err        (err),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer result, then range check against the signed WIDTH-bit window.
    function automatic void model(input longint a, input longint b, input int s, input bit st,
                                  output longint q, output bit ov, output bit er);
        longint hi, lo, full;
        logic [W-1:0] va, vb, vr;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        va = a[W-1:0];
        vb = b[W-1:0];
        er = 1'b0;
        full = 0;
        case (s)
            0: full = a + b;
            1: full = a - b;
            4: full = a * b;
            2: begin vr = va | vb; full = longint'($signed(vr)); end
            3: begin vr = va & vb; full = longint'($signed(vr)); end
            5: begin vr = va ^ vb; full = longint'($signed(vr)); end
            default: er = 1'b1;
        endcase
        ov = (full > hi) || (full < lo);
        if (!ov)
            q = full;
        else if (st)
            q = (full > 0) ? hi : lo;
        else begin
            vr = full[W-1:0];
            q = longint'($signed(vr));
        end
    endfunction

    task automatic run_op(input longint a, input longint b, input int s, input bit st,
                          input int hold, input bit clr);
        longint eq;
        bit eov, eer;
        int lat, exp_lat;
        model(a, b, s, st, eq, eov, eer);
        check_val("in_ready_idle", in_ready, 1);
        A = a[W-1:0];
        B = b[W-1:0];
        sel = s[2:0];
        sat = st;
        clr_sticky = clr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_sticky = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        sel = 3'($urandom);
        sat = ~st;
        if (clr) st_m = 1'b0;
        if (eov) st_m = 1'b1;
        exp_lat = (s == 4) ? W + 1 : 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_val("in_ready_busy", in_ready, 0);
        end while (!out_valid && lat < 40);
        check_val("latency", lat, exp_lat);
        check_val("Q", longint'($signed(Q)), eq);
        check_val("overflow", overflow, eov);
        check_val("err", err, eer);
        check_val("sticky", ovf_sticky, st_m);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = W'($urandom);
            sel = 3'($urandom_range(0, 3));
            @(negedge clk);
            check_val("bp_valid", out_valid, 1);
            check_val("bp_Q", longint'($signed(Q)), eq);
            check_val("bp_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("exit_ready", in_ready, 1);
        check_val("exit_valid", out_valid, 0);
        check_val("held_Q", longint'($signed(Q)), eq);
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        #1;
        check_val("rst_Q", Q, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_err", err, 0);
        check_val("rst_sticky", ovf_sticky, 0);
        #11;
        rst_n = 1'b1;

        run_op(100, 50, 0, 0, 0, 0);
        run_op(100, 50, 0, 1, 0, 0);
        run_op(-128, 1, 1, 0, 1, 0);
        run_op(-128, 1, 1, 1, 0, 0);
        run_op(-128, -128, 1, 0, 0, 0);
        run_op(12, -10, 4, 0, 0, 0);
        run_op(-128, -128, 4, 1, 0, 0);
        run_op(-128, -128, 4, 0, 2, 0);
        run_op(0, -5, 4, 1, 0, 0);
        run_op(5, 6, 0, 0, 5, 0);
        run_op(37, -90, 6, 0, 0, 0);
        run_op(-1, 1, 7, 1, 1, 0);
        run_op(100, 50, 0, 0, 0, 1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        st_m = 1'b0;
        check_val("clr_alone", ovf_sticky, 0);

        // Abandon a multiply part-way through with an asynchronous reset.
        run_op(100, 50, 0, 0, 0, 0);
        A = 8'd12;
        B = 8'd5;
        sel = 3'b100;
        sat = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_Q", Q, 0);
        check_val("midrst_valid", out_valid, 0);
        check_val("midrst_ovf", overflow, 0);
        check_val("midrst_sticky", ovf_sticky, 0);
        st_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("no_valid_after_rst", seen, 0);
        run_op(3, 4, 0, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(longint'($signed(ra)), longint'($signed(rb)), int'($urandom_range(0, 7)),
                   bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port in_valid  input  1  operand set and op presented.
REQ-005 Port in_ready  output  1  unit can accept a new operation.
REQ-006 Port A  input  WIDTH  signed operand A, two's complement.
REQ-007 Port B  input  WIDTH  signed operand B, two's complement.
REQ-008 Port sel  input  3  opcode: 000 add, 001 sub, 010 or, 011 and, 100 mul, 101 xor, 110/111 illegal.
REQ-009 Port sat  input  1  saturate on overflow (1) or wrap (0); sampled with operands.
REQ-010 Port out_valid  output  1  Q/overflow/err hold a completed result.
REQ-011 Port out_ready  input  1  consumer takes the result.
REQ-012 Port Q  output  WIDTH  signed result.
REQ-013 Port overflow  output  1  signed overflow of this result.
REQ-014 Port err  output  1  illegal opcode for this result.
REQ-015 Port ovf_sticky  output  1  set by any overflow result; cleared only by clr_sticky or reset.
REQ-016 Port clr_sticky  input  1  synchronous clear of ovf_sticky.

Function
REQ-017 FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-018 Accept occurs on a clock edge with in_valid=1 and in_ready=1; A, B, sel, sat registered internally at accept; later input changes have no effect.
REQ-019 IDLE -> DONE on accept of any op except mul; result and out_valid visible the cycle after accept (latency 1).
REQ-020 IDLE -> MUL on accept of mul; MUL runs exactly WIDTH cycles of shift-add on operand magnitudes, then -> DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-021 DONE: out_valid=1; Q, overflow, err stable; DONE -> IDLE on edge with out_ready=1; otherwise hold indefinitely.
REQ-022 No new accept in the DONE-exit cycle; next accept earliest one cycle after out_valid/out_ready handshake.
REQ-023 Add/sub: full-precision WIDTH+1 bit signed result; overflow=1 iff it lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 Mul: 2*WIDTH bit signed product, sign = A[msb] XOR B[msb], applied after magnitude multiply; zero product is never negative; overflow rule as REQ-023.
REQ-025 Overflow with sat=0: Q = low WIDTH bits of full result (wrap).
REQ-026 Overflow with sat=1: Q = 2^(WIDTH-1)-1 if full result positive, -2^(WIDTH-1) if negative.
REQ-027 No overflow: Q = exact result, regardless of sat.
REQ-028 or/and/xor: bitwise on A, B; overflow=0.
REQ-029 Illegal sel: Q=0, overflow=0, err=1, latency 1; err=0 for all legal ops.
REQ-030 ovf_sticky sets on the edge entering DONE with overflow=1; if clr_sticky=1 on the same edge, set wins.
REQ-031 Q, overflow, err hold last result after DONE -> IDLE until next result is written.

Reset
REQ-032 rst_n=0 forces immediately, without clock: state IDLE, in_ready=1 after release, out_valid=0, Q=0, overflow=0, err=0, ovf_sticky=0, multiplier datapath cleared.
REQ-033 Reset during MUL or DONE abandons the operation; no result is ever presented for it.
REQ-034 First accept possible on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-035 add 100+50, sat=0 -> Q=-106, overflow=1, ovf_sticky=1, out_valid one cycle after accept; same with sat=1 -> Q=127.
REQ-036 sub -128-1, sat=0 -> Q=127, overflow=1; sat=1 -> Q=-128; sub -128-(-128) -> Q=0, overflow=0.
REQ-037 mul 12 * -10 -> Q=-120, overflow=0, out_valid exactly 9 cycles after accept, in_ready=0 throughout; mul -128*-128, sat=1 -> Q=127, overflow=1; mul 0*-5 -> Q=0.
REQ-038 Backpressure: out_ready=0 for 5 cycles after result -> out_valid, Q stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-039 rst_n pulsed low mid-MUL (cycle 4) -> outputs zero asynchronously, no out_valid afterwards; new add 3+4 after release -> Q=7.
REQ-040 sel=110 -> Q=0, err=1, overflow=0; clr_sticky=1 coincident with an overflowing result -> ovf_sticky stays 1; clr_sticky alone -> 0.
